// File: rtl/fc_pkg.sv
// Shared types and saturation helpers for the fully-connected layer sequencer.
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC   = 3'd1,
        BIAS  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } fc_seq_state_t;

    // Largest value representable in a signed field of w bits.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Smallest value representable in a signed field of w bits.
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Multiply-accumulate datapath with bias add, rescale and output saturation.
// Optional feature macro: FC_SEQ_RELU_EN clamps negative results to zero.
module fc_mac_unit
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         add_en,
    input  logic                         bias_en,
    input  logic signed [DATA_WIDTH-1:0] w_data,
    input  logic signed [DATA_WIDTH-1:0] x_data,
    input  logic signed [DATA_WIDTH-1:0] b_data,
    output logic signed [DATA_WIDTH-1:0] out_data
);

    // One guard bit so the bias add cannot wrap on top of the accumulator.
    localparam int SW = ACC_WIDTH + 1;
    localparam logic signed [SW-1:0] MAXV = SW'(sat_max(DATA_WIDTH));
    localparam logic signed [SW-1:0] MINV = SW'(sat_min(DATA_WIDTH));

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [ACC_WIDTH-1:0]    acc_nxt;
    logic signed [SW-1:0]           biased;
    logic signed [SW-1:0]           shifted;
    logic signed [DATA_WIDTH-1:0]   sat_res;
    logic signed [DATA_WIDTH-1:0]   res_out;

    assign prod    = w_data * x_data;
    assign acc_nxt = add_en ? acc + ACC_WIDTH'(prod) : acc;

    // The final product lands in the same cycle as the bias, so use acc_nxt.
    assign biased  = SW'(acc_nxt) + (SW'(b_data) <<< FRAC_BITS);
    assign shifted = biased >>> FRAC_BITS;

    always_comb begin
        sat_res = shifted[DATA_WIDTH-1:0];
        if (shifted > MAXV)
            sat_res = MAXV[DATA_WIDTH-1:0];
        else if (shifted < MINV)
            sat_res = MINV[DATA_WIDTH-1:0];
    end

`ifdef FC_SEQ_RELU_EN
    assign res_out = sat_res[DATA_WIDTH-1] ? '0 : sat_res;
`else
    assign res_out = sat_res;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            out_data <= '0;
        end else begin
            if (clr)
                acc <= '0;
            else
                acc <= acc_nxt;
            if (bias_en)
                out_data <= res_out;
        end
    end

endmodule

// File: rtl/fc_layer_sequencer.sv
// FSM and address generation for one fully-connected layer pass.
// Optional feature macro: FC_SEQ_RELU_EN (handled in fc_mac_unit).
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int INPUT_SIZE  = 784,
    parameter int OUTPUT_SIZE = 128,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int ACC_WIDTH   = 40,
    localparam int WA = ($clog2(INPUT_SIZE*OUTPUT_SIZE) > 0) ? $clog2(INPUT_SIZE*OUTPUT_SIZE) : 1,
    localparam int XA = ($clog2(INPUT_SIZE) > 0) ? $clog2(INPUT_SIZE) : 1,
    localparam int BA = ($clog2(OUTPUT_SIZE) > 0) ? $clog2(OUTPUT_SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [WA-1:0]         w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [XA-1:0]         x_addr,
    input  logic [DATA_WIDTH-1:0] x_data,
    output logic [BA-1:0]         b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BA-1:0]         out_addr,
    output logic [DATA_WIDTH-1:0] out_data
);

    localparam logic [XA-1:0] LAST_J = XA'(INPUT_SIZE - 1);
    localparam logic [BA-1:0] LAST_I = BA'(OUTPUT_SIZE - 1);

    fc_seq_state_t state, state_nxt;
    logic [BA-1:0] i;
    logic [XA-1:0] j;
    logic [WA-1:0] w_base;
    logic          add_en;
    logic          clr;
    logic          bias_en;
    logic          in_mac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        bias_en   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr       = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                if (j == LAST_J)
                    state_nxt = BIAS;
            end
            BIAS: begin
                bias_en   = 1'b1;
                state_nxt = WRITE;
            end
            WRITE: begin
                if (out_ready) begin
                    clr       = 1'b1;
                    state_nxt = (i == LAST_I) ? DONE : MAC;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // w_base tracks i*INPUT_SIZE so the weight address needs no multiplier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i      <= '0;
            j      <= '0;
            w_base <= '0;
            add_en <= 1'b0;
        end else begin
            add_en <= in_mac;
            if (state == IDLE && start) begin
                i      <= '0;
                j      <= '0;
                w_base <= '0;
            end else if (in_mac) begin
                j <= (j == LAST_J) ? '0 : j + XA'(1);
            end else if (state == WRITE && out_ready && i != LAST_I) begin
                i      <= i + BA'(1);
                j      <= '0;
                w_base <= w_base + WA'(INPUT_SIZE);
            end
        end
    end

    assign in_mac    = (state == MAC);
    assign w_addr    = in_mac ? w_base + WA'(j) : '0;
    assign x_addr    = in_mac ? j : '0;
    assign b_addr    = in_mac ? i : '0;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign out_valid = (state == WRITE);
    assign out_addr  = i;

    fc_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .add_en   (add_en),
        .bias_en  (bias_en),
        .w_data   (w_data),
        .x_data   (x_data),
        .b_data   (b_data),
        .out_data (out_data)
    );

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Self-checking bench: two instances (FRAC_BITS 0 and 4) against a behavioural layer model.
module tb_fc_layer_sequencer;

    localparam int IN  = 4;
    localparam int OUT = 2;
    localparam int PASS_LEN = OUT * (IN + 2);

    logic clk, rst_n, start, out_ready;
    logic        busy0, done0, out_valid0, busy1, done1, out_valid1;
    logic [2:0]  w_addr0, w_addr1;
    logic [1:0]  x_addr0, x_addr1;
    logic [0:0]  b_addr0, b_addr1, out_addr0, out_addr1;
    logic [15:0] w_data0, x_data0, b_data0, w_data1, x_data1, b_data1;
    logic [15:0] out_data0, out_data1;

    logic signed [15:0] wmem [IN*OUT];
    logic signed [15:0] xmem [IN];
    logic signed [15:0] bmem [OUT];

    int nchk = 0, nfail = 0;
    int hs_cnt = 0, done_cnt = 0;
    int wr0 [OUT];
    int wr1 [OUT];
    bit pass_m = 0;
    int nt = 0, exp_idx = 0;

    fc_layer_sequencer #(.INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .DATA_WIDTH(16),
                         .FRAC_BITS(0), .ACC_WIDTH(40)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy0), .done(done0),
        .w_addr(w_addr0), .w_data(w_data0), .x_addr(x_addr0), .x_data(x_data0),
        .b_addr(b_addr0), .b_data(b_data0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_addr(out_addr0), .out_data(out_data0));

    fc_layer_sequencer #(.INPUT_SIZE(IN), .OUTPUT_SIZE(OUT), .DATA_WIDTH(16),
                         .FRAC_BITS(4), .ACC_WIDTH(40)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy1), .done(done1),
        .w_addr(w_addr1), .w_data(w_data1), .x_addr(x_addr1), .x_data(x_data1),
        .b_addr(b_addr1), .b_data(b_data1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_addr(out_addr1), .out_data(out_data1));

    initial clk = 0;
    always #5 clk = ~clk;

    // Synchronous memories: data one cycle after the address.
    always @(posedge clk) begin
        w_data0 <= wmem[w_addr0];
        x_data0 <= xmem[x_addr0];
        b_data0 <= bmem[b_addr0];
        w_data1 <= wmem[w_addr1];
        x_data1 <= xmem[x_addr1];
        b_data1 <= bmem[b_addr1];
    end

    task automatic check(input string name, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Neuron k: dot product wrapped to 40 bits, bias scaled in, rescaled, saturated.
    function automatic int model_out(input int k, input int frac);
        longint acc, s;
        acc = 0;
        for (int jj = 0; jj < IN; jj++)
            acc += longint'(wmem[k*IN + jj]) * longint'(xmem[jj]);
        acc = (acc <<< 24) >>> 24;
        s = (acc + (longint'(bmem[k]) <<< frac)) >>> frac;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef FC_SEQ_RELU_EN
        if (s < 0) s = 0;
`endif
        return int'(s);
    endfunction

    // Cycle-level expectations: each neuron takes IN+1 cycles before its result is
    // offered, then is held until accepted; after the last accept comes one done cycle.
    always @(negedge clk) begin : compare
        bit pw, ev, ed;
        if (!rst_n) begin
            pass_m  = 0;
            nt      = 0;
            exp_idx = 0;
        end else begin
            ev = pass_m && exp_idx < OUT && nt >= IN + 1;
            ed = pass_m && exp_idx == OUT;
            check("busy0", busy0, pass_m);
            check("busy1", busy1, pass_m);
            check("done0", done0, ed);
            check("done1", done1, ed);
            check("valid0", out_valid0, ev);
            check("valid1", out_valid1, ev);
            if (ev) begin
                check("addr0", out_addr0, exp_idx);
                check("addr1", out_addr1, exp_idx);
                check("data0", $signed(out_data0), model_out(exp_idx, 0));
                check("data1", $signed(out_data1), model_out(exp_idx, 4));
                if (out_ready) begin
                    wr0[exp_idx] = int'($signed(out_data0));
                    wr1[exp_idx] = int'($signed(out_data1));
                    hs_cnt++;
                end
            end
            if (done0) done_cnt++;
            pw = pass_m;
            if (ed)
                pass_m = 0;
            else if (ev && out_ready) begin
                exp_idx++;
                nt = 0;
            end else if (pass_m)
                nt++;
            if (!pw && start) begin
                pass_m  = 1;
                nt      = 0;
                exp_idx = 0;
            end
        end
    end

    task automatic check_zero(input string name);
        check({name, "_dut0"}, {busy0, done0, out_valid0, out_data0, out_addr0, w_addr0, x_addr0, b_addr0}, 0);
        check({name, "_dut1"}, {busy1, done1, out_valid1, out_data1, out_addr1, w_addr1, x_addr1, b_addr1}, 0);
    endtask

    task automatic load_basic();
        for (int k = 0; k < IN; k++) xmem[k] = 16'(k + 1);
        wmem[0] = 1; wmem[1] = 1; wmem[2] = 1;  wmem[3] = 1;
        wmem[4] = 2; wmem[5] = 0; wmem[6] = -1; wmem[7] = 1;
        bmem[0] = 5; bmem[1] = -3;
    endtask

    task automatic clear_wr();
        for (int k = 0; k < OUT; k++) begin
            wr0[k] = 99999;
            wr1[k] = 99999;
        end
    endtask

    // mode 0: ready held high; 1: random ready; 2: five stalled WRITE cycles; 3: stray starts.
    task automatic run_pass(input int mode, output int cyc);
        int stalls, sc, hs_b, dn_b;
        logic [15:0] cap_d;
        logic [0:0]  cap_a;
        hs_b = hs_cnt; dn_b = done_cnt;
        stalls = 0; sc = 0; cap_d = '0; cap_a = '0;
        clear_wr();
        @(posedge clk); #1;
        start = 1;
        out_ready = (mode == 2) ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        start = 0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (done0) break;
            if (cyc > 300) begin
                check("pass_timeout", cyc, PASS_LEN);
                break;
            end
            if (out_valid0 && !out_ready) begin
                stalls++;
                if (mode == 2) begin
                    if (sc == 0) begin
                        cap_d = out_data0;
                        cap_a = out_addr0;
                    end
                    sc++;
                    if (sc == 5) begin
                        check("stall_data_stable", out_data0, cap_d);
                        check("stall_addr_stable", out_addr0, cap_a);
                    end
                end
            end
            if (mode == 3 && cyc == 2) start = 1;
            @(posedge clk); cyc++; #1;
            start = 0;
            if (mode == 1) out_ready = 1'($urandom_range(0, 1));
            else if (mode == 2) out_ready = (sc >= 5);
        end
        if (mode == 3) start = 1;
        @(posedge clk); #1;
        start = 0;
        out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("pass_len", cyc, PASS_LEN + stalls);
        check("writes_per_pass", hs_cnt - hs_b, OUT);
        check("done_pulses", done_cnt - dn_b, 1);
    endtask

    int cyc;
    int neg_sat;

    initial begin
        rst_n = 0; start = 0; out_ready = 1;
        load_basic();
        clear_wr();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst_n = 1;
        repeat (3) @(posedge clk);

        // Basic pass with hand-computed results.
        run_pass(0, cyc);
        check("basic_len", cyc, 12);
        check("basic_n0_f0", wr0[0], 15);
        check("basic_n1_f0", wr0[1], 0);
        check("basic_n0_f4", wr1[0], 5);
        check("basic_n1_f4", wr1[1], -3);

        // Saturation both directions.
        for (int k = 0; k < IN*OUT; k++) wmem[k] = 16'sd32767;
        for (int k = 0; k < IN; k++) xmem[k] = 16'sd32767;
        for (int k = 0; k < OUT; k++) bmem[k] = 0;
        run_pass(0, cyc);
        check("sat_pos_f0", wr0[1], 32767);
        check("sat_pos_f4", wr1[0], 32767);
        for (int k = 0; k < IN*OUT; k++) wmem[k] = -16'sd32767;
`ifdef FC_SEQ_RELU_EN
        neg_sat = 0;
`else
        neg_sat = -32768;
`endif
        run_pass(0, cyc);
        check("sat_neg_f0", wr0[0], neg_sat);
        check("sat_neg_f4", wr1[1], neg_sat);

        // Backpressure and stray starts.
        load_basic();
        run_pass(2, cyc);
        check("bp_len", cyc, 17);
        check("bp_n0", wr0[0], 15);
        run_pass(3, cyc);
        check("stray_len", cyc, 12);
        check("stray_n1", wr1[1], -3);

        // Reset in the middle of MAC.
        @(posedge clk); #1; start = 1;
        @(posedge clk); #1; start = 0;
        repeat (2) @(posedge clk);
        #2; rst_n = 0;
        #1; check_zero("midmac_reset");
        @(posedge clk); #1;
        check_zero("reset_held");
        rst_n = 1;
        repeat (4) @(posedge clk);
        run_pass(0, cyc);
        check("after_reset_len", cyc, 12);
        check("after_reset_n0", wr0[0], 15);
        check("after_reset_n1", wr0[1], 0);

        // Randomized contents and random backpressure.
        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < IN*OUT; k++)
                wmem[k] = (p % 2) ? 16'($urandom_range(0, 65535)) : 16'(int'($urandom_range(0, 600)) - 300);
            for (int k = 0; k < IN; k++)
                xmem[k] = (p % 2) ? 16'($urandom_range(0, 65535)) : 16'(int'($urandom_range(0, 600)) - 300);
            for (int k = 0; k < OUT; k++)
                bmem[k] = 16'(int'($urandom_range(0, 2000)) - 1000);
            run_pass(1, cyc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
